// File: rtl/axi_lite_initiator.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_initiator
// Description : Single-outstanding AXI4-Lite initiator. Turns one request
//               (read or write) from a valid/ready request port into an
//               AXI-Lite transaction and returns the captured response.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_initiator #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rstn,
    // request port
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
    // response port
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    // AW channel
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    // W channel
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    // B channel
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    // AR channel
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    // R channel
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    localparam int c_STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t                    r_state;
    logic                      r_req_ready;
    logic                      r_rsp_valid;
    logic [DATA_WIDTH-1:0]     r_rsp_rdata;
    logic [1:0]                r_rsp_resp;
    logic [ADDR_WIDTH-1:0]     r_awaddr;
    logic                      r_awvalid;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [c_STRB_WIDTH-1:0]   r_wstrb;
    logic                      r_wvalid;
    logic                      r_bready;
    logic [ADDR_WIDTH-1:0]     r_araddr;
    logic                      r_arvalid;
    logic                      r_rready;

    // An AW or W beat counts as done once it has handshaken, either in an
    // earlier cycle (valid already dropped) or in the current one.
    logic w_aw_done;
    logic w_w_done;
    assign w_aw_done = !r_awvalid || m_axi_awready;
    assign w_w_done  = !r_wvalid  || m_axi_wready;

    assign req_ready     = r_req_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;
    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;

    // Transaction FSM; every output is updated here so all of them are registered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b00;
            r_awaddr    <= '0;
            r_awvalid   <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_araddr    <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_req_ready <= 1'b1;
                    if (req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        if (req_write) begin
                            r_awaddr  <= req_addr;
                            r_wdata   <= req_wdata;
                            r_wstrb   <= req_wstrb;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= WR_REQ;
                        end else begin
                            r_araddr  <= req_addr;
                            r_arvalid <= 1'b1;
                            r_state   <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    // AW and W retire independently; move on once both are through.
                    if (r_awvalid && m_axi_awready) begin
                        r_awvalid <= 1'b0;
                    end
                    if (r_wvalid && m_axi_wready) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axi_bvalid) begin
                        r_bready    <= 1'b0;
                        r_rsp_resp  <= m_axi_bresp;
                        r_rsp_rdata <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                RD_REQ: begin
                    if (m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_axi_rvalid) begin
                        r_rready    <= 1'b0;
                        r_rsp_rdata <= m_axi_rdata;
                        r_rsp_resp  <= m_axi_rresp;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_initiator
// Description : Self-checking bench for axi_lite_initiator: behavioural
//               memory slave with programmable latencies, word-memory
//               reference model and per-cycle channel protocol checks.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_axi_lite_initiator;

    localparam int c_AW = 13;
    localparam int c_DW = 32;
    localparam int c_SW = 4;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_write = 1'b0;
    logic [c_AW-1:0]  req_addr = '0;
    logic [c_DW-1:0]  req_wdata = '0;
    logic [c_SW-1:0]  req_wstrb = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [c_DW-1:0]  rsp_rdata;
    logic [1:0]       rsp_resp;
    logic [c_AW-1:0]  m_axi_awaddr;
    logic             m_axi_awvalid;
    logic             m_axi_awready = 1'b0;
    logic [c_DW-1:0]  m_axi_wdata;
    logic [c_SW-1:0]  m_axi_wstrb;
    logic             m_axi_wvalid;
    logic             m_axi_wready = 1'b0;
    logic [1:0]       m_axi_bresp = 2'b00;
    logic             m_axi_bvalid = 1'b0;
    logic             m_axi_bready;
    logic [c_AW-1:0]  m_axi_araddr;
    logic             m_axi_arvalid;
    logic             m_axi_arready = 1'b0;
    logic [c_DW-1:0]  m_axi_rdata = '0;
    logic [1:0]       m_axi_rresp = 2'b00;
    logic             m_axi_rvalid = 1'b0;
    logic             m_axi_rready;

    always #5 clk = ~clk;

    axi_lite_initiator #(.ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW)) u_dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // reference model and slave storage (one word per byte address)
    logic [c_DW-1:0] model_mem [0:8191];
    logic [c_DW-1:0] slave_mem [0:8191];
    logic [c_AW-1:0] pool [8];

    // slave configuration for the current transaction
    int         cfg_aw_d, cfg_w_d, cfg_b_d, cfg_ar_d, cfg_r_d;
    logic [1:0] cfg_resp;

    // slave state
    bit              aw_done, w_done, b_pend, b_hs, r_pend, r_hs;
    int              aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic [c_AW-1:0] cap_awaddr, cap_araddr;
    logic [c_DW-1:0] cap_wdata;
    logic [c_SW-1:0] cap_wstrb;
    // monitor state from the previous cycle
    bit              mon_aw_wait, mon_aw_hs, mon_w_wait, mon_w_hs, mon_ar_wait, mon_ar_hs;
    logic [c_AW-1:0] mon_awaddr, mon_araddr;
    logic [c_DW-1:0] mon_wdata;
    logic [c_SW-1:0] mon_wstrb;
    // per-transaction cycle counts of each valid/ready being high
    int              cnt_aw, cnt_w, cnt_b, cnt_ar, cnt_r;

    task automatic slave_reset();
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
        m_axi_bvalid = 1'b0; m_axi_rvalid = 1'b0;
        aw_done = 0; w_done = 0; b_pend = 0; b_hs = 0; r_pend = 0; r_hs = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        mon_aw_wait = 0; mon_aw_hs = 0; mon_w_wait = 0; mon_w_hs = 0;
        mon_ar_wait = 0; mon_ar_hs = 0;
    endtask

    // Memory slave plus protocol monitor, evaluated on the falling edge.
    initial begin : slave_proc
        slave_reset();
        forever begin
            @(negedge clk);
            if (!rstn) begin
                slave_reset();
            end else begin
                if (mon_aw_wait) begin
                    check("aw_hold_valid", m_axi_awvalid, 1);
                    check("aw_hold_addr", m_axi_awaddr, mon_awaddr);
                end
                if (mon_aw_hs) check("aw_drop", m_axi_awvalid, 0);
                if (mon_w_wait) begin
                    check("w_hold_valid", m_axi_wvalid, 1);
                    check("w_hold_data", {m_axi_wstrb, m_axi_wdata}, {mon_wstrb, mon_wdata});
                end
                if (mon_w_hs) check("w_drop", m_axi_wvalid, 0);
                if (mon_ar_wait) begin
                    check("ar_hold_valid", m_axi_arvalid, 1);
                    check("ar_hold_addr", m_axi_araddr, mon_araddr);
                end
                if (mon_ar_hs) check("ar_drop", m_axi_arvalid, 0);
                cnt_aw += int'(m_axi_awvalid);
                cnt_w  += int'(m_axi_wvalid);
                cnt_b  += int'(m_axi_bready);
                cnt_ar += int'(m_axi_arvalid);
                cnt_r  += int'(m_axi_rready);

                // B response
                if (b_hs) begin
                    m_axi_bvalid = 1'b0; b_hs = 0; b_pend = 0;
                end else if (b_pend && !m_axi_bvalid) begin
                    if (b_cnt >= cfg_b_d) begin
                        m_axi_bvalid = 1'b1; m_axi_bresp = cfg_resp;
                    end else b_cnt++;
                end
                if (m_axi_bvalid && m_axi_bready) b_hs = 1;

                // R response
                if (r_hs) begin
                    m_axi_rvalid = 1'b0; r_hs = 0; r_pend = 0;
                end else if (r_pend && !m_axi_rvalid) begin
                    if (r_cnt >= cfg_r_d) begin
                        m_axi_rvalid = 1'b1; m_axi_rresp = cfg_resp;
                        m_axi_rdata = slave_mem[cap_araddr];
                    end else r_cnt++;
                end
                if (m_axi_rvalid && m_axi_rready) r_hs = 1;

                // AW
                m_axi_awready = 1'b0;
                if (m_axi_awvalid && !aw_done) begin
                    if (aw_cnt >= cfg_aw_d) begin
                        m_axi_awready = 1'b1; aw_done = 1; cap_awaddr = m_axi_awaddr;
                    end else aw_cnt++;
                end
                mon_aw_wait = m_axi_awvalid && !m_axi_awready;
                mon_aw_hs   = m_axi_awvalid && m_axi_awready;
                mon_awaddr  = m_axi_awaddr;

                // W
                m_axi_wready = 1'b0;
                if (m_axi_wvalid && !w_done) begin
                    if (w_cnt >= cfg_w_d) begin
                        m_axi_wready = 1'b1; w_done = 1;
                        cap_wdata = m_axi_wdata; cap_wstrb = m_axi_wstrb;
                    end else w_cnt++;
                end
                mon_w_wait = m_axi_wvalid && !m_axi_wready;
                mon_w_hs   = m_axi_wvalid && m_axi_wready;
                mon_wdata  = m_axi_wdata;
                mon_wstrb  = m_axi_wstrb;

                // AR
                m_axi_arready = 1'b0;
                if (m_axi_arvalid && !r_pend) begin
                    if (ar_cnt >= cfg_ar_d) begin
                        m_axi_arready = 1'b1; cap_araddr = m_axi_araddr;
                        r_pend = 1; r_cnt = 0; ar_cnt = 0;
                    end else ar_cnt++;
                end
                mon_ar_wait = m_axi_arvalid && !m_axi_arready;
                mon_ar_hs   = m_axi_arvalid && m_axi_arready;
                mon_araddr  = m_axi_araddr;

                // both write beats received: commit and schedule B
                if (aw_done && w_done) begin
                    if (cfg_resp == 2'b00) begin
                        for (int b = 0; b < c_SW; b++)
                            if (cap_wstrb[b]) slave_mem[cap_awaddr][8*b +: 8] = cap_wdata[8*b +: 8];
                    end
                    aw_done = 0; w_done = 0; aw_cnt = 0; w_cnt = 0;
                    b_pend = 1; b_cnt = 0;
                end
            end
        end
    end

    task automatic do_txn(input bit wr, input logic [c_AW-1:0] addr, input logic [c_DW-1:0] wd,
                          input logic [c_SW-1:0] ws, input logic [1:0] resp,
                          input int aw_d, input int w_d, input int b_d,
                          input int ar_d, input int r_d, input int rsp_d);
        logic [c_DW-1:0] exp_rdata;
        int n;
        cfg_aw_d = aw_d; cfg_w_d = w_d; cfg_b_d = b_d;
        cfg_ar_d = ar_d; cfg_r_d = r_d; cfg_resp = resp;
        exp_rdata = wr ? '0 : model_mem[addr];
        if (wr && resp == 2'b00) begin
            for (int b = 0; b < c_SW; b++)
                if (ws[b]) model_mem[addr][8*b +: 8] = wd[8*b +: 8];
        end
        @(negedge clk);
        cnt_aw = 0; cnt_w = 0; cnt_b = 0; cnt_ar = 0; cnt_r = 0;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_wstrb = ws;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (!req_ready) begin
            check("req_accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'($urandom); req_addr = c_AW'($urandom);
        req_wdata = $urandom; req_wstrb = c_SW'($urandom);
        if (wr) begin
            check("aw_first", m_axi_awvalid, 1);
            check("w_first", m_axi_wvalid, 1);
            check("awaddr", m_axi_awaddr, addr);
            check("wdata", m_axi_wdata, wd);
            check("wstrb", m_axi_wstrb, ws);
        end else begin
            check("ar_first", m_axi_arvalid, 1);
            check("araddr", m_axi_araddr, addr);
        end
        n = 0;
        while (!rsp_valid && n < 200) begin
            check("busy_req_ready", req_ready, 0);
            @(negedge clk); n++;
        end
        if (!rsp_valid) begin
            check("rsp_timeout", 0, 1);
            return;
        end
        for (int i = 0; i < rsp_d; i++) begin
            check("rsp_hold_valid", rsp_valid, 1);
            check("rsp_hold_rdata", rsp_rdata, exp_rdata);
            check("rsp_hold_resp", rsp_resp, resp);
            check("rsp_hold_req_ready", req_ready, 0);
            @(negedge clk);
        end
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_resp", rsp_resp, resp);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_drop", rsp_valid, 0);
        check("idle_req_ready", req_ready, 1);
        check("cnt_awvalid", cnt_aw, wr ? aw_d + 1 : 0);
        check("cnt_wvalid", cnt_w, wr ? w_d + 1 : 0);
        check("cnt_bready", cnt_b, wr ? b_d + 1 : 0);
        check("cnt_arvalid", cnt_ar, wr ? 0 : ar_d + 1);
        check("cnt_rready", cnt_r, wr ? 0 : r_d + 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valids"}, {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                                 m_axi_bready, m_axi_rready, rsp_valid}, 0);
        check({tag, "_rsp"}, {rsp_resp, rsp_rdata}, 0);
        check({tag, "_addr"}, {m_axi_awaddr, m_axi_araddr}, 0);
        check({tag, "_wdata"}, {m_axi_wstrb, m_axi_wdata}, 0);
    endtask

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        logic [1:0] rr;
        for (int i = 0; i < 8192; i++) begin model_mem[i] = '0; slave_mem[i] = '0; end
        pool[0] = 13'h000; pool[1] = 13'h004; pool[2] = 13'h010; pool[3] = 13'h013;
        pool[4] = 13'h024; pool[5] = 13'h100; pool[6] = 13'h1FFC; pool[7] = 13'h1FFF;
        cfg_aw_d = 0; cfg_w_d = 0; cfg_b_d = 0; cfg_ar_d = 0; cfg_r_d = 0; cfg_resp = 2'b00;

        // reset state and release
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rstn = 1'b1;
        @(negedge clk);
        check("release_req_ready", req_ready, 1);

        // write with always-ready slave, then read it back
        do_txn(1, 13'h010, 32'hDEADBEEF, 4'hF, 2'b00, 0, 0, 0, 0, 0, 0);
        do_txn(0, 13'h010, '0, '0, 2'b00, 0, 0, 0, 2, 0, 0);
        // W lags AW by three cycles
        do_txn(1, 13'h024, 32'h1234_5678, 4'hF, 2'b00, 0, 3, 0, 0, 0, 0);
        do_txn(0, 13'h024, '0, '0, 2'b00, 0, 0, 0, 0, 1, 0);
        // AW lags W, partial strobe
        do_txn(1, 13'h010, 32'hA5A5_A5A5, 4'b0101, 2'b00, 2, 0, 1, 0, 0, 1);
        // SLVERR read with a slow consumer
        do_txn(0, 13'h010, '0, '0, 2'b10, 0, 0, 0, 1, 0, 5);
        // DECERR write leaves memory untouched
        do_txn(1, 13'h010, 32'hFFFF_FFFF, 4'hF, 2'b11, 1, 1, 2, 0, 0, 0);
        do_txn(0, 13'h010, '0, '0, 2'b00, 0, 0, 0, 0, 0, 0);

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            n = int'($urandom_range(0, 7));
            rr = (n < 6) ? 2'b00 : ((n == 6) ? 2'b10 : 2'b11);
            do_txn(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], $urandom,
                   c_SW'($urandom), rr,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        // reset while waiting for B
        cfg_aw_d = 0; cfg_w_d = 0; cfg_b_d = 20; cfg_resp = 2'b10;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 13'h004;
        req_wdata = 32'hCAFE_F00D; req_wstrb = 4'hF;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!m_axi_bready && n < 50) begin @(negedge clk); n++; end
        check("in_wr_resp", m_axi_bready, 1);
        #2 rstn = 1'b0;
        #1 check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("rerelease_req_ready", req_ready, 1);
        check("rerelease_rsp_valid", rsp_valid, 0);
        do_txn(0, 13'h004, '0, '0, 2'b00, 0, 0, 0, 1, 1, 0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_lite_initiator.md
AXI_LITE_INITIATOR -- requirements
Module: axi_lite_initiator

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 13, byte address width of the request port and the AXI port.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width (strobe width DATA_WIDTH/8).
REQ-003 SHALL have port clk  input  1  rising-edge clock for all logic.
REQ-004 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  request offered.
REQ-006 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-007 SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  ADDR_WIDTH  byte address.
REQ-009 SHALL have port req_wdata  input  DATA_WIDTH  write data.
REQ-010 SHALL have port req_wstrb  input  DATA_WIDTH/8  byte strobes.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  response consumed.
REQ-013 SHALL have port rsp_rdata  output  DATA_WIDTH  read data (0 for writes).
REQ-014 SHALL have port rsp_resp  output  2  captured BRESP/RRESP.
REQ-015 SHALL have ports m_axi_awaddr (output, ADDR_WIDTH), m_axi_awvalid (output, 1) and m_axi_awready (input, 1) forming the AW channel.
REQ-016 SHALL have ports m_axi_wdata (output, DATA_WIDTH), m_axi_wstrb (output, DATA_WIDTH/8), m_axi_wvalid (output, 1) and m_axi_wready (input, 1) forming the W channel.
REQ-017 SHALL have ports m_axi_bresp (input, 2), m_axi_bvalid (input, 1) and m_axi_bready (output, 1) forming the B channel.
REQ-018 SHALL have ports m_axi_araddr (output, ADDR_WIDTH), m_axi_arvalid (output, 1) and m_axi_arready (input, 1) forming the AR channel.
REQ-019 SHALL have ports m_axi_rdata (input, DATA_WIDTH), m_axi_rresp (input, 2), m_axi_rvalid (input, 1) and m_axi_rready (output, 1) forming the R channel.

Function
REQ-020 SHALL implement the FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA and RESP, with one transaction outstanding at most.
REQ-021 SHALL drive req_ready=1 only in IDLE; on req_valid&&req_ready it SHALL register addr, wdata and wstrb, then enter WR_REQ if req_write=1, else RD_REQ.
REQ-022 SHALL, in WR_REQ, assert m_axi_awvalid and m_axi_wvalid together in the first cycle after acceptance; each SHALL drop the cycle after its own handshake (valid&&ready), independently of the other.
REQ-023 SHALL leave WR_REQ for WR_RESP once both AW and W have handshaken, whether in the same cycle or in different cycles, in any order.
REQ-024 SHALL assert m_axi_bready only in WR_RESP; on m_axi_bvalid it SHALL capture bresp into rsp_resp, set rsp_rdata=0 and enter RESP.
REQ-025 SHALL assert m_axi_arvalid in RD_REQ until m_axi_arready, then enter RD_DATA.
REQ-026 SHALL assert m_axi_rready only in RD_DATA; on m_axi_rvalid it SHALL capture rdata and rresp, then enter RESP.
REQ-027 SHALL hold rsp_valid=1 in RESP, with rsp_rdata/rsp_resp stable, until rsp_ready; it SHALL then return to IDLE, and req_ready SHALL be high the following cycle.
REQ-028 SHALL never deassert any AXI valid before its handshake, and SHALL hold addr/data/strb stable while the corresponding valid is high.
REQ-029 SHALL drive all outputs from registers; the AXI address SHALL equal req_addr unmodified (byte address, no shifting or alignment).
REQ-030 SHALL pass SLVERR/DECERR responses through in rsp_resp without retry.
REQ-031 SHALL ignore req_valid outside IDLE, and SHALL ignore unexpected bvalid/rvalid when the matching ready is low.

Reset
REQ-032 SHALL, while rstn=0, force the state to IDLE and drive all valids, m_axi_bready, m_axi_rready, rsp_valid, rsp_rdata, rsp_resp and the AXI addr/data/strb outputs to 0; req_ready SHALL go high in the first cycle after release.
REQ-033 SHALL abandon an in-flight transaction when reset asserts mid-operation, with no response issued.

Verification
REQ-034 SHALL be verified with: write addr 0x010, data 0xDEADBEEF, strb 0xF, slave ready always -> AW and W handshake in the same cycle, bready asserted, rsp_resp=00, rsp_rdata=0.
REQ-035 SHALL be verified with: read addr 0x010 after that write, from a memory slave -> arvalid high until arready, then rsp_rdata=0xDEADBEEF, rsp_resp=00.
REQ-036 SHALL be verified with: write where wready lags awready by 3 cycles -> awvalid drops after its handshake while wvalid is held for 3 cycles; exactly one B wait follows.
REQ-037 SHALL be verified with: slave returns rresp=2'b10 and rsp_ready held low for 5 cycles -> rsp_valid stays high for 5 cycles with rsp_resp=10 stable; req_ready stays 0 throughout.
REQ-038 SHALL be verified with: rstn pulsed low while in WR_RESP -> all valids/readies go to 0 immediately, no rsp_valid, and a new read request is accepted after release.
